// File: rtl/kernel_nios2_cpu_ocimem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : kernel_nios2_cpu_ocimem_pkg
//  Description : Shared types and default widths for the OCI RAM arbiter.
//                This package declares the arbiter FSM states, the owner
//                identifiers used for round-robin and read-response
//                routing, and the default address and data widths.
//  Revision    : 1.0 - initial release
// ============================================================================
package kernel_nios2_cpu_ocimem_pkg;

    localparam int c_default_addr_w = 8;
    localparam int c_default_data_w = 32;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } state_t;

    typedef enum logic [0:0] {
        OWN_JTAG = 1'b0,
        OWN_AVS  = 1'b1
    } owner_t;

endpackage
`default_nettype wire

// File: rtl/kernel_nios2_cpu_ocimem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : kernel_nios2_cpu_ocimem_arbiter_if
//  Description : Bundles the JTAG debug-slave command port, the CPU
//                debug-memory Avalon slave and the single-port RAM port.
//                slave  : arbiter side (takes requests, drives the RAM)
//                master : environment side (requesters and RAM model)
//  Revision    : 1.0 - initial release
// ============================================================================
interface kernel_nios2_cpu_ocimem_arbiter_if
    import kernel_nios2_cpu_ocimem_pkg::*;
#(
    parameter int ADDR_W = c_default_addr_w,
    parameter int DATA_W = c_default_data_w
);
    // JTAG command port
    logic                  jtag_cmd_valid;
    logic                  jtag_cmd_write;
    logic [ADDR_W-1:0]     jtag_addr;
    logic [DATA_W-1:0]     jtag_wdata;
    logic                  jtag_clr_overrun;
    logic [DATA_W-1:0]     jtag_rdata;
    logic                  jtag_rdata_valid;
    logic                  jtag_busy;
    logic                  jtag_overrun;
    // Avalon debug-memory slave
    logic [ADDR_W-1:0]     avs_address;
    logic                  avs_read;
    logic                  avs_write;
    logic [DATA_W-1:0]     avs_writedata;
    logic [DATA_W/8-1:0]   avs_byteenable;
    logic                  avs_waitrequest;
    logic [DATA_W-1:0]     avs_readdata;
    logic                  avs_readdatavalid;
    // Single-port RAM
    logic [ADDR_W-1:0]     ram_addr;
    logic                  ram_we;
    logic [DATA_W/8-1:0]   ram_be;
    logic [DATA_W-1:0]     ram_wdata;
    logic [DATA_W-1:0]     ram_rdata;

    modport slave (
        input  jtag_cmd_valid, jtag_cmd_write, jtag_addr, jtag_wdata,
               jtag_clr_overrun,
               avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
               ram_rdata,
        output jtag_rdata, jtag_rdata_valid, jtag_busy, jtag_overrun,
               avs_waitrequest, avs_readdata, avs_readdatavalid,
               ram_addr, ram_we, ram_be, ram_wdata
    );

    modport master (
        output jtag_cmd_valid, jtag_cmd_write, jtag_addr, jtag_wdata,
               jtag_clr_overrun,
               avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
               ram_rdata,
        input  jtag_rdata, jtag_rdata_valid, jtag_busy, jtag_overrun,
               avs_waitrequest, avs_readdata, avs_readdatavalid,
               ram_addr, ram_we, ram_be, ram_wdata
    );

endinterface
`default_nettype wire

// File: rtl/kernel_nios2_cpu_ocimem_jtag_buf.sv
`default_nettype none
// ============================================================================
//  Module      : kernel_nios2_cpu_ocimem_jtag_buf
//  Description : One-entry holding buffer for JTAG debug-slave commands.
//                The JTAG strobe cannot be stalled, so a strobe that finds
//                the buffer occupied (and not draining this cycle) is lost
//                and recorded in a sticky overrun flag.
//  Ports       : clk, reset          - clock, synchronous active-high reset
//                i_load, i_write,
//                i_addr, i_wdata     - command strobe and its payload
//                i_drain             - buffered command granted this cycle
//                i_clr_overrun       - clears the overrun flag
//                o_full, o_overrun   - occupancy and sticky loss flag
//                o_write, o_addr,
//                o_wdata             - buffered command payload
//  Revision    : 1.0 - initial release
// ============================================================================
module kernel_nios2_cpu_ocimem_jtag_buf
    import kernel_nios2_cpu_ocimem_pkg::*;
#(
    parameter int ADDR_W = c_default_addr_w,
    parameter int DATA_W = c_default_data_w
) (
    input  wire logic              clk,
    input  wire logic              reset,
    input  wire logic              i_load,
    input  wire logic              i_write,
    input  wire logic [ADDR_W-1:0] i_addr,
    input  wire logic [DATA_W-1:0] i_wdata,
    input  wire logic              i_drain,
    input  wire logic              i_clr_overrun,
    output logic                   o_full,
    output logic                   o_overrun,
    output logic                   o_write,
    output logic [ADDR_W-1:0]      o_addr,
    output logic [DATA_W-1:0]      o_wdata
);

    logic              r_full;
    logic              r_overrun;
    logic              r_write;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;

    logic w_accept;
    logic w_drop;

    // A strobe in the grant cycle frees the slot and refills it at once.
    assign w_accept = i_load & (~r_full | i_drain);
    assign w_drop   = i_load &  r_full & ~i_drain;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_full    <= 1'b0;
            r_overrun <= 1'b0;
            r_write   <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
        end else begin
            if (w_accept) begin
                r_full  <= 1'b1;
                r_write <= i_write;
                r_addr  <= i_addr;
                r_wdata <= i_wdata;
            end else if (i_drain) begin
                r_full  <= 1'b0;
            end
            // A fresh loss outranks a simultaneous clear.
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (i_clr_overrun) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign o_full    = r_full;
    assign o_overrun = r_overrun;
    assign o_write   = r_write;
    assign o_addr    = r_addr;
    assign o_wdata   = r_wdata;

endmodule
`default_nettype wire

// File: rtl/kernel_nios2_cpu_ocimem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : kernel_nios2_cpu_ocimem_arbiter
//  Description : Shares one single-port OCI RAM between the JTAG debug
//                slave (buffered, non-stallable strobes) and the CPU
//                debug-memory Avalon slave (stalled via waitrequest).
//                Grants happen only in IDLE; a read grant spends one
//                RD_WAIT cycle so the RAM data can be routed back to the
//                read's owner. Conflicts resolve round-robin.
//  Ports       : clk, reset - clock, synchronous active-high reset
//                bus        - JTAG, Avalon and RAM signal bundle (slave side)
//  Revision    : 1.0 - initial release
// ============================================================================
module kernel_nios2_cpu_ocimem_arbiter
    import kernel_nios2_cpu_ocimem_pkg::*;
#(
    parameter int ADDR_W = c_default_addr_w,
    parameter int DATA_W = c_default_data_w
) (
    input  wire logic                       clk,
    input  wire logic                       reset,
    kernel_nios2_cpu_ocimem_arbiter_if.slave bus
);

    localparam int c_be_w = DATA_W / 8;

    state_t             r_state;
    owner_t             r_last_owner;
    owner_t             r_rd_owner;
    logic               r_jtag_rvalid;
    logic [DATA_W-1:0]  r_jtag_rdata;

    logic               w_buf_full;
    logic               w_buf_overrun;
    logic               w_buf_write;
    logic [ADDR_W-1:0]  w_buf_addr;
    logic [DATA_W-1:0]  w_buf_wdata;

    logic               w_avs_req;
    logic               w_grant_jtag;
    logic               w_grant_avs;
    logic               w_grant;
    logic               w_grant_wr;

    kernel_nios2_cpu_ocimem_jtag_buf #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_jtag_buf (
        .clk           (clk),
        .reset         (reset),
        .i_load        (bus.jtag_cmd_valid),
        .i_write       (bus.jtag_cmd_write),
        .i_addr        (bus.jtag_addr),
        .i_wdata       (bus.jtag_wdata),
        .i_drain       (w_grant_jtag),
        .i_clr_overrun (bus.jtag_clr_overrun),
        .o_full        (w_buf_full),
        .o_overrun     (w_buf_overrun),
        .o_write       (w_buf_write),
        .o_addr        (w_buf_addr),
        .o_wdata       (w_buf_wdata)
    );

    // Read+write together is treated as a write.
    assign w_avs_req = bus.avs_read | bus.avs_write;

    // Grant decision; nothing is granted while reset is asserted.
    always_comb begin
        w_grant_jtag = 1'b0;
        w_grant_avs  = 1'b0;
        if (!reset && r_state == IDLE) begin
            if (w_buf_full && w_avs_req) begin
                if (r_last_owner == OWN_AVS) begin
                    w_grant_jtag = 1'b1;
                end else begin
                    w_grant_avs  = 1'b1;
                end
            end else begin
                w_grant_jtag = w_buf_full;
                w_grant_avs  = w_avs_req;
            end
        end
    end

    assign w_grant    = w_grant_jtag | w_grant_avs;
    assign w_grant_wr = w_grant_jtag ? w_buf_write : (w_grant_avs & bus.avs_write);

    // RAM request from the current owner.
    assign bus.ram_addr  = w_grant_avs ? bus.avs_address   : w_buf_addr;
    assign bus.ram_wdata = w_grant_avs ? bus.avs_writedata : w_buf_wdata;
    assign bus.ram_we    = w_grant_wr;
    assign bus.ram_be    = w_grant_avs  ? bus.avs_byteenable :
                           w_grant_jtag ? {c_be_w{1'b1}}     : {c_be_w{1'b0}};

    // Avalon response comes straight from the RAM in the RD_WAIT cycle;
    // gating with reset suppresses the response of a read cut short.
    assign bus.avs_waitrequest   = w_avs_req & ~w_grant_avs;
    assign bus.avs_readdata      = bus.ram_rdata;
    assign bus.avs_readdatavalid = (r_state == RD_WAIT) & (r_rd_owner == OWN_AVS) & ~reset;

    assign bus.jtag_rdata       = r_jtag_rdata;
    assign bus.jtag_rdata_valid = r_jtag_rvalid;
    assign bus.jtag_busy        = w_buf_full;
    assign bus.jtag_overrun     = w_buf_overrun;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_last_owner  <= OWN_AVS;
            r_rd_owner    <= OWN_AVS;
            r_jtag_rvalid <= 1'b0;
            r_jtag_rdata  <= '0;
        end else begin
            r_jtag_rvalid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_grant) begin
                        r_last_owner <= w_grant_jtag ? OWN_JTAG : OWN_AVS;
                        if (!w_grant_wr) begin
                            r_state    <= RD_WAIT;
                            r_rd_owner <= w_grant_jtag ? OWN_JTAG : OWN_AVS;
                        end
                    end
                end
                RD_WAIT: begin
                    r_state <= IDLE;
                    // JTAG data is registered for the MonDReg path.
                    if (r_rd_owner == OWN_JTAG) begin
                        r_jtag_rdata  <= bus.ram_rdata;
                        r_jtag_rvalid <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
